// File: rtl/fft_pkg.sv
// Shared sizes and core-state encoding for the 16-point FFT frame sequencer.
package fft_pkg;

   localparam int unsigned N   = 16;               // points per frame
   localparam int unsigned DW  = 16;               // input sample width
   localparam int unsigned YW  = 32;               // output bin width
   localparam int unsigned IW  = $clog2(N);        // bin index width
   localparam int unsigned FCW = $clog2(N + 1);    // fill count width, must reach N

   typedef enum logic [1:0] {
      C_IDLE  = 2'd0,
      C_WAIT  = 2'd1,
      C_DRAIN = 2'd2
   } core_state_e;

endpackage

// File: rtl/fft_drain_serializer.sv
// Captures the parallel FFT bins and drains them one per handshake on a valid/ready port.
module fft_drain_serializer
   import fft_pkg::*;
(
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            capture_i,
   input  logic [N*YW-1:0] bins_i,
   output logic [YW-1:0]   m_data_o,
   output logic            m_valid_o,
   input  logic            m_ready_i,
   output logic            m_last_o,
   output logic [IW-1:0]   m_index_o,
   output logic            last_done_o
);

   logic [YW-1:0] obuf_q [N];
   logic [IW-1:0] index_q;
   logic          active_q;
   logic          at_last;

   assign at_last     = (index_q == IW'(N - 1));
   assign m_valid_o   = active_q;
   assign m_data_o    = obuf_q[index_q];
   assign m_last_o    = active_q && at_last;
   assign m_index_o   = index_q;
   assign last_done_o = active_q && m_ready_i && at_last;

   // Bin buffer and beat pointer; pointer wraps to 0 on the final beat
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int k = 0; k < N; k++) obuf_q[k] <= '0;
         index_q  <= '0;
         active_q <= 1'b0;
      end else if (capture_i) begin
         for (int k = 0; k < N; k++) obuf_q[k] <= bins_i[k*YW +: YW];
         index_q  <= '0;
         active_q <= 1'b1;
      end else if (active_q && m_ready_i) begin
         index_q <= index_q + IW'(1);
         if (at_last) active_q <= 1'b0;
      end
   end

endmodule

// File: rtl/fft_frame_sequencer.sv
// Collects serial samples into frames, launches them into main_fft, waits out the core
// latency, then hands the bins to the drain serializer.
module fft_frame_sequencer
   import fft_pkg::*;
#(
   parameter int unsigned FFT_LAT = 3
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic [DW-1:0]   s_data_i,
   input  logic            s_valid_i,
   output logic            s_ready_o,
   output logic [N*DW-1:0] fft_x_o,
   input  logic [N*YW-1:0] fft_y_i,
   output logic [YW-1:0]   m_data_o,
   output logic            m_valid_o,
   input  logic            m_ready_i,
   output logic            m_last_o,
   output logic [IW-1:0]   m_index_o,
   output logic            busy_o,
   output logic [7:0]      frames_done_o
);

   localparam int unsigned WCW = (FFT_LAT > 1) ? $clog2(FFT_LAT) : 1;
   localparam int unsigned FDW = 8;

   core_state_e     state_q;
   logic [FCW-1:0]  fill_cnt_q;
   logic [DW-1:0]   fbuf_q [N];
   logic [N*DW-1:0] hold_q;
   logic [WCW-1:0]  wait_cnt_q;
   logic            busy_q;
   logic [FDW-1:0]  frames_done_q;
   logic            frame_full;
   logic            accept;
   logic            capture;
   logic            last_done;

   assign frame_full    = (fill_cnt_q == FCW'(N));
   assign s_ready_o     = !rst_i && !frame_full;
   assign accept        = s_valid_i && s_ready_o;
   assign capture       = (state_q == C_WAIT) && (wait_cnt_q == '0);
   assign fft_x_o       = hold_q;
   assign busy_o        = busy_q;
   assign frames_done_o = frames_done_q;

   // Fill buffer; contents are only meaningful up to fill_cnt, so it carries no reset
   always_ff @(posedge clk_i) begin
      if (accept) fbuf_q[fill_cnt_q[IW-1:0]] <= s_data_i;
   end

   // Fill counter and core FSM; accept and launch are exclusive since launch needs a full frame
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q       <= C_IDLE;
         fill_cnt_q    <= '0;
         hold_q        <= '0;
         wait_cnt_q    <= '0;
         busy_q        <= 1'b0;
         frames_done_q <= '0;
      end else begin
         if (accept) fill_cnt_q <= fill_cnt_q + FCW'(1);
         case (state_q)
            C_IDLE: begin
               if (frame_full) begin
                  for (int k = 0; k < N; k++) hold_q[k*DW +: DW] <= fbuf_q[k];
                  fill_cnt_q <= '0;
                  wait_cnt_q <= WCW'(FFT_LAT - 1);
                  busy_q     <= 1'b1;
                  state_q    <= C_WAIT;
               end
            end
            C_WAIT: begin
               if (wait_cnt_q == '0) state_q    <= C_DRAIN;
               else                  wait_cnt_q <= wait_cnt_q - WCW'(1);
            end
            C_DRAIN: begin
               if (last_done) begin
                  frames_done_q <= frames_done_q + FDW'(1);
                  busy_q        <= 1'b0;
                  state_q       <= C_IDLE;
               end
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= C_IDLE;
            end
         endcase
      end
   end

   fft_drain_serializer u_drain (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .capture_i   (capture),
      .bins_i      (fft_y_i),
      .m_data_o    (m_data_o),
      .m_valid_o   (m_valid_o),
      .m_ready_i   (m_ready_i),
      .m_last_o    (m_last_o),
      .m_index_o   (m_index_o),
      .last_done_o (last_done)
   );

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Directed bench for fft_frame_sequencer with a registered main_fft stub.
module tb_fft_frame_sequencer;
   import fft_pkg::*;

   localparam int unsigned FFT_LAT = 3;

   logic            clk = 1'b0;
   logic            rst;
   logic [DW-1:0]   s_data;
   logic            s_valid;
   logic            s_ready;
   logic [N*DW-1:0] fft_x;
   logic [N*YW-1:0] fft_y;
   logic [YW-1:0]   m_data;
   logic            m_valid;
   logic            m_ready;
   logic            m_last;
   logic [IW-1:0]   m_index;
   logic            busy;
   logic [7:0]      frames_done;

   int unsigned n_total = 0;
   int unsigned n_pass  = 0;

   logic [DW-1:0] x2 [N] = '{16'hFD00, 16'hFE00, 16'hFF00, 16'h0000, 16'h0100, 16'h0200,
                             16'h0300, 16'h0400, 16'h0400, 16'h0300, 16'h0200, 16'h0100,
                             16'h0000, 16'h0000, 16'h0100, 16'h0200};

   logic [YW-1:0] beat_d [$];
   logic [IW-1:0] beat_i [$];
   logic          beat_l [$];

   always #5 clk = ~clk;

   fft_frame_sequencer #(.FFT_LAT(FFT_LAT)) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .s_data_i      (s_data),
      .s_valid_i     (s_valid),
      .s_ready_o     (s_ready),
      .fft_x_o       (fft_x),
      .fft_y_i       (fft_y),
      .m_data_o      (m_data),
      .m_valid_o     (m_valid),
      .m_ready_i     (m_ready),
      .m_last_o      (m_last),
      .m_index_o     (m_index),
      .busy_o        (busy),
      .frames_done_o (frames_done)
   );

   // Core stub: bin k = {x_k, k}; two register stages so the bins sampled FFT_LAT edges
   // after the launch edge reflect the launched frame
   logic [N*DW-1:0] st1, st2;
   always @(posedge clk) begin
      st1 <= fft_x;
      st2 <= st1;
   end
   always_comb begin
      for (int k = 0; k < N; k++) fft_y[k*YW +: YW] = {st2[k*DW +: DW], 16'(k)};
   end

   // Record every accepted output beat
   always @(posedge clk) begin
      if (!rst && m_valid && m_ready) begin
         beat_d.push_back(m_data);
         beat_i.push_back(m_index);
         beat_l.push_back(m_last);
      end
   end

   task automatic check(input string tag, input int idx, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, idx, obs, exp);
   endtask

   function automatic logic [DW-1:0] samp(input int j);
      return DW'(j * 37 + 32'h1234);
   endfunction

   task automatic clear_q();
      beat_d.delete();
      beat_i.delete();
      beat_l.delete();
   endtask

   // Offer n samples (table or generated) at the given duty, waiting out s_ready=0
   task automatic feed(input int n, input int duty, input bit tbl);
      int i = 0;
      int g = 0;
      while (i < n && g < n * 40 + 500) begin
         s_valid = (int'($urandom_range(0, 99)) < duty);
         s_data  = tbl ? x2[i % N] : samp(i);
         if (s_valid && s_ready) i++;
         @(negedge clk);
         g++;
      end
      s_valid = 1'b0;
      check("feed_count", 0, 64'(i), 64'(n));
   endtask

   task automatic wait_beats(input int n);
      int g = 0;
      while (beat_d.size() < n && g < n * 8 + 200) begin
         @(negedge clk);
         g++;
      end
      repeat (2) @(negedge clk);
      check("beat_count", 0, 64'(beat_d.size()), 64'(n));
   endtask

   task automatic check_beats(input int n, input bit tbl);
      for (int j = 0; j < n; j++) begin
         logic [DW-1:0] e;
         e = tbl ? x2[j % N] : samp(j);
         check("beat", j, {27'd0, beat_d[j], beat_i[j], beat_l[j]},
               {27'd0, e, 16'(j % N), 4'(j % N), (j % N) == N - 1});
      end
   endtask

   initial begin
      logic [N*DW-1:0] xp;
      logic [YW-1:0]   pd;
      logic [IW-1:0]   pi;
      logic            pl;
      logic            stall;
      int              c;
      int              i;
      int              g;

      rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
      pd = '0; pi = '0; pl = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_s_ready", 0, 64'(s_ready), 64'(0));
      check("rst_m_valid", 0, 64'(m_valid), 64'(0));
      check("rst_busy", 0, 64'(busy), 64'(0));
      check("rst_frames_done", 0, 64'(frames_done), 64'(0));
      for (int k = 0; k < 4; k++) check("rst_fft_x", k, fft_x[k*64 +: 64], 64'(0));
      rst = 1'b0;
      @(negedge clk);
      check("s_ready_after_rst", 0, 64'(s_ready), 64'(1));

      // Single frame, latency, slice order
      clear_q();
      for (int k = 0; k < N; k++) xp[k*DW +: DW] = x2[k];
      feed(16, 100, 1'b1);
      check("lat_m_valid", 0, 64'(m_valid), 64'(0));
      @(negedge clk);
      for (int k = 0; k < N; k++) check("fft_x", k, 64'(fft_x[k*DW +: DW]), 64'(x2[k]));
      check("busy_launch", 0, 64'(busy), 64'(1));
      check("lat_m_valid", 1, 64'(m_valid), 64'(0));
      @(negedge clk);
      check("lat_m_valid", 2, 64'(m_valid), 64'(0));
      @(negedge clk);
      check("lat_m_valid", 3, 64'(m_valid), 64'(0));
      check("fft_x_hold", 0, 64'(fft_x === xp), 64'(1));
      @(negedge clk);
      check("lat_m_valid", 4, 64'(m_valid), 64'(1));
      check("first_beat", 0, 64'(m_data), 64'(32'hFD00_0000));
      wait_beats(16);
      check_beats(16, 1'b1);
      check("frames_done_t2", 0, 64'(frames_done), 64'(1));

      // Backpressure with m_ready pattern 1,0,0
      clear_q();
      m_ready = 1'b0;
      feed(16, 100, 1'b1);
      stall = 1'b0;
      c = 0;
      while (beat_d.size() < 16 && c < 200) begin
         if (stall)
            check("bp_hold", c, {26'd0, m_valid, m_index, m_last, m_data}, {26'd0, 1'b1, pi, pl, pd});
         m_ready = (c % 3 == 0);
         stall = m_valid && !m_ready;
         pd = m_data; pi = m_index; pl = m_last;
         @(negedge clk);
         c++;
      end
      m_ready = 1'b1;
      wait_beats(16);
      check_beats(16, 1'b1);
      check("frames_done_t3", 0, 64'(frames_done), 64'(2));

      // Overlap: 48 samples streamed, sink stalled through the first drain
      clear_q();
      m_ready = 1'b0;
      i = 0;
      g = 0;
      while (g < 60) begin
         s_valid = (i < 48);
         s_data  = samp(i);
         if (s_valid && s_ready) i++;
         @(negedge clk);
         g++;
      end
      check("ovl_accepts_stalled", 0, 64'(i), 64'(32));
      check("ovl_s_ready_low", 0, 64'(s_ready), 64'(0));
      check("ovl_stalled_beat", 0, {59'd0, m_valid, m_index}, {59'd0, 1'b1, 4'd0});
      m_ready = 1'b1;
      while (i < 48 && g < 400) begin
         s_valid = 1'b1;
         s_data  = samp(i);
         if (s_ready) i++;
         @(negedge clk);
         g++;
      end
      s_valid = 1'b0;
      check("ovl_accepts", 0, 64'(i), 64'(48));
      wait_beats(48);
      check_beats(48, 1'b0);
      check("frames_done_t4", 0, 64'(frames_done), 64'(5));

      // Reset in the middle of a drain, with a partial next frame already filling
      clear_q();
      feed(16, 100, 1'b1);
      g = 0;
      s_valid = 1'b1;
      s_data  = 16'hDEAD;
      while (beat_d.size() < 5 && g < 50) begin
         @(negedge clk);
         g++;
      end
      check("rst_mid_beats", 0, 64'(beat_d.size()), 64'(5));
      rst = 1'b1;
      s_valid = 1'b0;
      @(negedge clk);
      check("mid_rst_m_valid", 0, 64'(m_valid), 64'(0));
      check("mid_rst_busy", 0, 64'(busy), 64'(0));
      check("mid_rst_s_ready", 0, 64'(s_ready), 64'(0));
      check("mid_rst_index", 0, 64'(m_index), 64'(0));
      check("mid_rst_frames_done", 0, 64'(frames_done), 64'(0));
      rst = 1'b0;
      clear_q();
      @(negedge clk);
      check("mid_rst_release", 0, 64'(s_ready), 64'(1));
      feed(16, 100, 1'b1);
      wait_beats(16);
      check_beats(16, 1'b1);
      check("frames_done_t5", 0, 64'(frames_done), 64'(1));

      // Gappy input, then frames_done wrap after 256 frames
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      clear_q();
      feed(16, 30, 1'b1);
      wait_beats(16);
      check_beats(16, 1'b1);
      check("frames_done_gappy", 0, 64'(frames_done), 64'(1));
      clear_q();
      feed(254 * 16, 100, 1'b0);
      wait_beats(254 * 16);
      check_beats(254 * 16, 1'b0);
      check("frames_done_255", 0, 64'(frames_done), 64'(255));
      clear_q();
      feed(16, 100, 1'b1);
      wait_beats(16);
      check_beats(16, 1'b1);
      check("frames_done_wrap", 0, 64'(frames_done), 64'(0));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
